// File: rtl/sram_rd_align.sv
// Read-side alignment stage: credit-gated issue into a fixed-latency SRAM,
// return capture into a small FIFO, and in-order delivery over valid/ready.
module sram_rd_align #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rd_latency,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic                  lat2_q;      // effective latency: 0 -> 1 cycle, 1 -> 2 cycles
  logic [1:0]            ret_v;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         inflight_d;
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           used;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  issue;
  logic                  ret;
  logic                  push;
  logic                  pop;

  // Credits come from registered state only, so a pop frees a slot next cycle.
  assign fifo_count = wr_ptr - rd_ptr;
  assign used       = {1'b0, fifo_count} + {1'b0, inflight};
  assign req_ready  = (used < DEPTH_W) & ~reset;

  assign issue      = req_valid & req_ready;
  assign sram_rd_en = issue;
  assign sram_addr  = issue ? req_addr : '0;

  assign ret        = lat2_q ? ret_v[1] : ret_v[0];
  assign push       = ret;
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_ready & out_valid;
  assign out_data   = mem[rd_ptr[PW-1:0]];
  assign busy       = (inflight != '0) | (fifo_count != '0);

  always_comb begin
    // NOTE: default first so every path assigns inflight_d and no latch is inferred.
    inflight_d = inflight;
    case ({issue, ret})
      2'b10:   inflight_d = inflight + CNT_ONE;
      2'b01:   inflight_d = inflight - CNT_ONE;
      default: inflight_d = inflight;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat2_q   <= 1'b0;
      ret_v    <= '0;
      inflight <= '0;
    end else begin
      ret_v    <= {ret_v[0], issue};
      inflight <= inflight_d;
      // Latency may only change while nothing is outstanding.
      if (!busy && !issue) lat2_q <= (rd_latency >= 2'd2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: storage is reset on purpose so out_data reads 0 before any write.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= sram_rdata;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_sram_rd_align.sv
// Directed bench for sram_rd_align: per-cycle vector tables for streaming and
// latency-change behaviour, plus hand sequences for backpressure and reset.
module tb_sram_rd_align;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    rd_latency;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          sram_rd_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_rd_align #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_latency (rd_latency),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .sram_rd_en (sram_rd_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // SRAM model: data = addr + 0x10, returned 1 or 2 cycles after the strobe.
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;
  logic          sram_lat2 = 1'b0;
  always @(posedge clk) begin
    if (sram_rd_en) d1 <= sram_addr[DW-1:0] + 8'h10;
    d2 <= d1;
  end
  assign sram_rdata = sram_lat2 ? d2 : d1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Order scoreboard and overflow guard, sampled well before the rising edge.
  logic [DW-1:0] exp_q[$];
  always @(negedge clk) begin
    #3;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (dut.push) check("push_not_full", 32'(dut.fifo_count == 3'(DEPTH)), 0);
      if (req_valid && req_ready) exp_q.push_back(8'(req_addr) + 8'h10);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("order_extra_word", 1, 0);
        else check("order", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]    rl;
    logic          sl2;
    logic          rv;
    logic [AW-1:0] addr;
    logic          ordy;
    logic          e_ready;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] rl, input logic sl2, input logic rv,
                              input logic [AW-1:0] addr, input logic ordy, input logic er,
                              input logic ev, input logic [DW-1:0] ed, input logic eb);
    vec_t v;
    v.rl = rl; v.sl2 = sl2; v.rv = rv; v.addr = addr; v.ordy = ordy;
    v.e_ready = er; v.e_valid = ev; v.e_data = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic en;
    @(negedge clk);
    rd_latency = v.rl;
    sram_lat2  = v.sl2;
    req_valid  = v.rv;
    req_addr   = v.addr;
    out_ready  = v.ordy;
    #1;
    en = v.rv & v.e_ready;
    check($sformatf("v%0d_req_ready", idx), req_ready, v.e_ready);
    check($sformatf("v%0d_sram_rd_en", idx), sram_rd_en, en);
    check($sformatf("v%0d_sram_addr", idx), sram_addr, en ? v.addr : '0);
    check($sformatf("v%0d_out_valid", idx), out_valid, v.e_valid);
    check($sformatf("v%0d_out_data", idx), out_data, v.e_data);
    check($sformatf("v%0d_busy", idx), busy, v.e_busy);
  endtask

  task automatic measure(input logic [1:0] rl, input logic sl2, input int exp_lat, input string name);
    int n;
    logic got;
    @(negedge clk);
    rd_latency = rl; sram_lat2 = sl2; req_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 10'h0A5;
    #1 check({name, "_accept"}, req_ready, 1);
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
      #1 if (out_valid) got = 1'b1;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_data"}, out_data, 8'hB5);
  endtask

  initial begin
    int acc;

    // Streaming at latency 1: first out_valid two cycles after first accept.
    for (int c = 0; c <= 10; c++)
      vecs.push_back(mk(2'd1, 1'b0, c < 8, AW'(c), 1'b1, 1'b1, (c >= 2 && c <= 9),
                        (c < 2) ? 8'h00 : (c <= 9) ? 8'(8'h10 + c - 2) : 8'h14,
                        (c >= 1 && c <= 9)));
    // rd_latency raised while busy: the second read still returns in one cycle.
    vecs.push_back(mk(2'd1, 1'b0, 1'b1, 10'h060, 1'b1, 1'b1, 1'b0, 8'h14, 1'b0));
    vecs.push_back(mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h14, 1'b1));
    vecs.push_back(mk(2'd2, 1'b0, 1'b1, 10'h061, 1'b1, 1'b1, 1'b1, 8'h70, 1'b1));
    vecs.push_back(mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h15, 1'b1));
    vecs.push_back(mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 8'h71, 1'b1));
    vecs.push_back(mk(2'd2, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 8'h16, 1'b0));
    // Streaming at latency 2: first out_valid three cycles after first accept, no bubbles.
    for (int c = 0; c <= 11; c++)
      vecs.push_back(mk(2'd2, 1'b1, c < 8, AW'(c), 1'b1, 1'b1, (c >= 3 && c <= 10),
                        (c < 3) ? 8'h16 : (c <= 10) ? 8'(8'h10 + c - 3) : 8'h14,
                        (c >= 1 && c <= 10)));

    reset = 1'b1; rd_latency = 2'd1; req_valid = 1'b0; req_addr = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("first_cycle_ready", req_ready, 1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // rd_latency 0 decodes as 1, 3 as 2.
    measure(2'd0, 1'b0, 2, "lat0");
    measure(2'd3, 1'b1, 3, "lat3");
    measure(2'd1, 1'b0, 2, "lat1");

    // Backpressure: with out_ready low only DEPTH requests are accepted.
    @(negedge clk);
    out_ready = 1'b0; req_valid = 1'b1; acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      req_addr = 10'h040 + AW'(acc);
      #1 if (req_ready) acc++;
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_ready_low", req_ready, 0);
    check("bp_busy", busy, 1);
    @(negedge clk);
    req_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_ready_during_pop", req_ready, 0);
    check("bp_head", out_data, 8'h50);
    @(negedge clk);
    out_ready = 1'b0; req_valid = 1'b1; req_addr = 10'h044;
    #1;
    check("bp_ready_after_pop", req_ready, 1);
    check("bp_head2", out_data, 8'h51);
    // Push and pop in the same cycle leave the occupancy unchanged.
    @(negedge clk);
    req_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("pp_ready_full_credit", req_ready, 0);
    check("pp_head", out_data, 8'h51);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("pp_ready_after", req_ready, 1);
    check("pp_head_after", out_data, 8'h52);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      check($sformatf("drain%0d_data", i), out_data, 8'(8'h52 + i));
    end
    @(negedge clk);
    #1;
    check("drain_empty", out_valid, 0);
    check("drain_idle", busy, 0);

    // Reset with two reads in flight and one word buffered.
    rd_latency = 2'd2; sram_lat2 = 1'b1; out_ready = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 10'h080 + AW'(i);
      #1 check($sformatf("rst_issue%0d", i), req_ready, 1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data", out_data, 8'h90);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1; req_valid = 1'b1; req_addr = 10'h3FF;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_sram_rd_en", sram_rd_en, 0);
    check("mid_rst_sram_addr", sram_addr, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("late_rdata%0d_valid", i), out_valid, 0);
      check($sformatf("late_rdata%0d_busy", i), busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
